tcp_stream_tx: RTL
==================

// Module: tcp_stream_tx
// PURPOSE
//  User-side transmit streamer for the raw TCP port of eth_vlg; it is the TX counterpart of the RX consumer.
//  Accepts bytes on a valid/ready interface and buffers them in a FIFO.
//  Forwards bytes to tcp_din/tcp_vin under tcp_cts flow control.
//  Pulses tcp_snd to push a segment on:
//    - size threshold reached
//    - idle timeout
//    - user flush request
//  Sits between application logic and eth_vlg in the clk_125m domain.
// PARAMETERS
//  FIFO_DEPTH      default 10     log2 of FIFO entries (1024 bytes)
//  SEND_THRESHOLD  default 1460   bytes forwarded before a forced tcp_snd; range 1..65535
//  IDLE_TICKS      default 1250   cycles with no forwarded byte, while a segment is open, before tcp_snd (10 us)
// PORTS
//  clk         in   1   125 MHz system clock
//  reset_n     in   1   synchronous reset, active low
//  connected   in   1   TCP connection established (from eth_vlg)
//  tcp_cts     in   1   stack can accept a byte this cycle
//  tcp_din     out  8   byte to stack
//  tcp_vin     out  1   tcp_din valid; a byte is transferred when tcp_vin is high
//  tcp_snd     out  1   one-cycle pulse: transmit the buffered segment now
//  usr_dat     in   8   user byte
//  usr_val     in   1   usr_dat valid
//  usr_rdy     out  1   streamer accepts a byte; a write occurs when usr_val && usr_rdy
//  usr_flush   in   1   pulse: push any open segment once the FIFO drains
//  bytes_sent  out  32  total bytes forwarded since reset; wraps modulo 2^32
// BEHAVIOUR
//  Reset (reset_n==0 at posedge):
//    - state=IDLE, FIFO empty, counters 0, flush_pend=0
//    - tcp_vin=0, tcp_snd=0, usr_rdy=0, tcp_din=0, bytes_sent=0
//  FSM states: IDLE, STREAM, PUSH.
//  IDLE:
//    - FIFO held empty, usr_rdy=0
//    - connected==1 -> STREAM
//  STREAM:
//    - usr_rdy = !full
//    - tcp_vin = !empty && tcp_cts && seg_cnt<SEND_THRESHOLD (combinational from registered FIFO head and tcp_cts)
//    - tcp_din = FIFO head (show-ahead); a pop occurs on tcp_vin
//    - Each pop: seg_cnt+1, bytes_sent+1, idle_cnt<=0
//    - No pop and seg_cnt>0: idle_cnt+1
//    - Exit to PUSH when any of the following hold (several true together -> a single PUSH):
//        (a) seg_cnt==SEND_THRESHOLD
//        (b) idle_cnt==IDLE_TICKS-1
//        (c) flush_pend && empty && seg_cnt>0
//    - flush_pend && empty && seg_cnt==0: clear flush_pend, no tcp_snd
//  PUSH:
//    - tcp_snd=1 for exactly one cycle, tcp_vin=0
//    - seg_cnt<=0, idle_cnt<=0
//    - flush_pend cleared only if the exit cause was (c)
//    - -> STREAM
//  usr_flush:
//    - Sets flush_pend in any state except IDLE
//    - A flush arriving in PUSH stays latched and is serviced later
//  Latency: a byte written at edge N is visible on tcp_din/tcp_vin in cycle N+1 at the earliest.
//  Full FIFO: usr_rdy=0, so no write can occur; a same-cycle pop re-opens usr_rdy in the next cycle.
//  connected falling (any state):
//    - -> IDLE next edge; FIFO contents and open segment discarded
//    - tcp_vin and tcp_snd forced 0 in the same cycle
//    - bytes_sent is kept
//  Counter widths: seg_cnt 16b, idle_cnt $clog2(IDLE_TICKS+1)b; neither counter wraps in normal operation.
// STRUCTURE
//  tcp_stream_pkg:
//    - typedef enum logic [1:0] {IDLE, STREAM, PUSH} tcp_stream_fsm_t
//    - seg_cnt_t (16b)
//  Sub-module tcp_stream_fifo: synchronous show-ahead FIFO
//    - width 8, depth 2**FIFO_DEPTH
//    - ports: full, empty, write, read, head
//  FSM, counters and output muxing live in tcp_stream_tx.
// TESTING
//  1. connected=1, write 8 bytes 0x00..0x07, tcp_cts=1 -> tcp_din 0x00..0x07 on consecutive cycles; IDLE_TICKS later one tcp_snd pulse; bytes_sent=8.
//  2. SEND_THRESHOLD=16, stream 40 bytes, cts=1 -> tcp_snd after byte 16 and byte 32, then idle snd after byte 40; no tcp_vin during PUSH.
//  3. tcp_cts toggled 1/0 every cycle during 20-byte burst -> tcp_vin never high while cts=0; bytes delivered in order without loss.
//  4. FIFO_DEPTH=4, cts=0, write until usr_rdy=0 -> exactly 16 bytes accepted; cts=1 -> usr_rdy=1 one cycle after first pop.
//  5. 5 bytes then usr_flush -> tcp_snd the cycle after FIFO empties (before IDLE_TICKS); usr_flush with nothing sent -> no tcp_snd.
//  6. connected dropped with 10 bytes buffered -> tcp_vin=0 same cycle, usr_rdy=0; reconnect -> FIFO empty; reset_n=0 mid-stream -> all outputs 0.

Source files
------------

// File: rtl/tcp_stream_pkg.sv
// tcp_stream_pkg
//   Shared types for the TCP transmit streamer: the FSM state encoding and
//   the segment byte counter type.
//   No ports (package).
package tcp_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PUSH   = 2'd2
  } tcp_stream_fsm_t;

  typedef logic [15:0] seg_cnt_t;

  localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/tcp_stream_fifo.sv
// tcp_stream_fifo
//   Synchronous show-ahead byte FIFO: head_o always presents the oldest
//   entry while empty_o is low, and read_i simply retires it.
// Ports:
//   clk_i     clock
//   rst_ni    synchronous reset, active low (pointers/count only)
//   clr_i     synchronous clear, discards all contents
//   write_i   push wdata_i (ignored when full)
//   wdata_i   byte to push
//   read_i    retire head (ignored when empty)
//   head_o    oldest byte
//   full_o    no free entry
//   empty_o   no valid entry
module tcp_stream_fifo
  import tcp_stream_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              write_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic              read_i,
  output logic [BYTE_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned ENTRIES = 2 ** FIFO_DEPTH;
  localparam logic [FIFO_DEPTH:0] CNT_FULL = {1'b1, {FIFO_DEPTH{1'b0}}};

  logic [BYTE_W-1:0]     mem_q [ENTRIES];
  logic [FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH:0]   cnt_q, cnt_d;
  logic                  do_wr, do_rd;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_wr = write_i && !full_o;
  assign do_rd = read_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk_i) begin
    if (do_wr && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tcp_stream_tx.sv
// tcp_stream_tx
//   User-side transmit streamer for the raw TCP port of eth_vlg. Buffers
//   user bytes in a FIFO, forwards them to the stack under tcp_cts, and
//   pulses tcp_snd on size threshold, idle timeout or user flush.
// Ports:
//   clk         125 MHz clock
//   reset_n     synchronous reset, active low
//   connected   TCP connection established
//   tcp_cts     stack can accept a byte this cycle
//   tcp_din     byte to stack
//   tcp_vin     tcp_din valid (transfer when high)
//   tcp_snd     one-cycle push of the buffered segment
//   usr_dat     user byte
//   usr_val     usr_dat valid
//   usr_rdy     streamer accepts a byte
//   usr_flush   push any open segment once the FIFO drains
//   bytes_sent  bytes forwarded since reset, wraps modulo 2^32
module tcp_stream_tx
  import tcp_stream_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 10,
  parameter int unsigned SEND_THRESHOLD = 1460,
  parameter int unsigned IDLE_TICKS     = 1250
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        connected,
  input  logic        tcp_cts,
  output logic [7:0]  tcp_din,
  output logic        tcp_vin,
  output logic        tcp_snd,
  input  logic [7:0]  usr_dat,
  input  logic        usr_val,
  output logic        usr_rdy,
  input  logic        usr_flush,
  output logic [31:0] bytes_sent
);

  localparam int unsigned IDLE_W = $clog2(IDLE_TICKS + 1);
  localparam seg_cnt_t          THRESH    = seg_cnt_t'(SEND_THRESHOLD);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TICKS - 1);

  tcp_stream_fsm_t   state_q, state_d;
  seg_cnt_t          seg_cnt_q, seg_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              cause_flush_q, cause_flush_d;
  logic [31:0]       bytes_q, bytes_d;

  logic              fifo_full, fifo_empty, fifo_clr, fifo_wr;
  logic [7:0]        fifo_head;
  logic              exit_thr, exit_idle, exit_flush;

  // The FIFO is held empty outside an established connection so that a
  // disconnect discards buffered bytes immediately.
  assign fifo_clr = (state_q == IDLE) || !connected;
  assign fifo_wr  = usr_rdy && usr_val;

  tcp_stream_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clr_i   (fifo_clr),
    .write_i (fifo_wr),
    .wdata_i (usr_dat),
    .read_i  (tcp_vin),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Push causes, all evaluated on registered counters. The idle term also
  // requires an open segment so a one-tick timeout cannot fire on nothing.
  assign exit_thr   = (seg_cnt_q == THRESH);
  assign exit_idle  = (idle_cnt_q == IDLE_LAST) && (seg_cnt_q != '0);
  assign exit_flush = flush_pend_q && fifo_empty && (seg_cnt_q != '0);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (connected) state_d = STREAM;
      STREAM: begin
        if (!connected) state_d = IDLE;
        else if (exit_thr || exit_idle || exit_flush) state_d = PUSH;
      end
      PUSH:    state_d = connected ? STREAM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; a dropped connection gates every handshake output at once.
  always_comb begin
    usr_rdy = 1'b0;
    tcp_vin = 1'b0;
    tcp_snd = 1'b0;
    tcp_din = '0;
    unique case (state_q)
      STREAM: begin
        usr_rdy = connected && !fifo_full;
        tcp_vin = connected && !fifo_empty && tcp_cts && (seg_cnt_q < THRESH);
        if (!fifo_empty) tcp_din = fifo_head;
      end
      PUSH:    tcp_snd = connected;
      default: ;
    endcase
  end

  assign bytes_sent = bytes_q;

  // Counters and flush bookkeeping
  always_comb begin
    seg_cnt_d     = seg_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    flush_pend_d  = flush_pend_q;
    cause_flush_d = cause_flush_q;
    bytes_d       = bytes_q;
    if (tcp_vin) bytes_d = bytes_q + 32'd1;
    unique case (state_q)
      STREAM: begin
        if (tcp_vin) begin
          seg_cnt_d  = seg_cnt_q + 16'd1;
          idle_cnt_d = '0;
        end else if (seg_cnt_q != '0) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        // Flush with nothing forwarded since the last push is simply dropped.
        if (flush_pend_q && fifo_empty && (seg_cnt_q == '0)) flush_pend_d = 1'b0;
        cause_flush_d = exit_flush;
        if (usr_flush) flush_pend_d = 1'b1;
      end
      PUSH: begin
        seg_cnt_d     = '0;
        idle_cnt_d    = '0;
        if (cause_flush_q) flush_pend_d = 1'b0;
        cause_flush_d = 1'b0;
        // A flush arriving during the push belongs to the next segment.
        if (usr_flush) flush_pend_d = 1'b1;
      end
      default: begin
        seg_cnt_d     = '0;
        idle_cnt_d    = '0;
        flush_pend_d  = 1'b0;
        cause_flush_d = 1'b0;
      end
    endcase
    if (!connected) begin
      seg_cnt_d     = '0;
      idle_cnt_d    = '0;
      flush_pend_d  = 1'b0;
      cause_flush_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      flush_pend_q  <= 1'b0;
      cause_flush_q <= 1'b0;
      bytes_q       <= '0;
    end else begin
      seg_cnt_q     <= seg_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      flush_pend_q  <= flush_pend_d;
      cause_flush_q <= cause_flush_d;
      bytes_q       <= bytes_d;
    end
  end

endmodule
